// File: rtl/mlp_seq_engine_pkg.sv
// Shared types and elaboration-time helpers for the sequential MLP engine.
package mlp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Minimum of 1 so that index vectors never collapse to zero width.
    function automatic int clog2(input int v);
        int r;
        int n;
        r = 0;
        n = 1;
        while (n < v) begin
            n = n * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Weight k sits MSB-first in the flat bus.
    function automatic int w_lsb(input int k, input int num_w, input int width_w);
        return (num_w - 1 - k) * width_w;
    endfunction

    function automatic int b0_lsb(input int h, input int width_b0);
        return h * width_b0;
    endfunction

    function automatic int b1_lsb(input int c, input int num_h, input int width_b0,
                                  input int width_b1);
        return num_h * width_b0 + c * width_b1;
    endfunction

endpackage

// File: rtl/mlp_seq_engine_mac.sv
// Shared signed MAC: one product per enabled cycle, either seeded with a bias or accumulated.
// sum is the combinational next value so the caller can act on a neuron's final total in its last cycle.
module mlp_mac #(
    parameter int AW    = 5,
    parameter int WW    = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] bias,
    input  logic signed [AW-1:0]    a,
    input  logic signed [WW-1:0]    w,
    output logic signed [ACC_W-1:0] sum
);
    localparam int PW = AW + WW;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] acc_q;

    assign prod = a * w;
    assign base = load ? bias : acc_q;
    assign sum  = base + {{(ACC_W-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mlp_seq_engine.sv
// Two-layer MLP evaluated term by term on one MAC; result after NUM_A*NUM_H+NUM_H*NUM_C cycles.
// Accepts only in IDLE; the argmax is held in DONE until out_ready, with no overlap with capture.
module mlp_seq_engine
    import mlp_seq_pkg::*;
#(
    parameter int NUM_A    = 6,
    parameter int WIDTH_A  = 4,
    parameter int NUM_H    = 3,
    parameter int NUM_C    = 3,
    parameter int WIDTH_W  = 8,
    parameter int WIDTH_B0 = 10,
    parameter int WIDTH_B1 = 11,
    parameter int OUTWIDTH = 2,
    parameter int QSHIFT   = 4,
    parameter int ACC_W    = 24,
    localparam int NUM_W   = NUM_A*NUM_H + NUM_H*NUM_C
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_A*WIDTH_A-1:0]                inp,
    input  logic [NUM_W*WIDTH_W-1:0]                weights,
    input  logic [NUM_H*WIDTH_B0+NUM_C*WIDTH_B1-1:0] biases,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [OUTWIDTH-1:0]                     out,
    output logic                                    busy
);
    localparam int XW = clog2(NUM_A);
    localparam int HW = clog2(NUM_H);
    localparam int CW = clog2(NUM_C);
    localparam int TW = max_int(XW, HW);
    localparam int NW = max_int(HW, CW);
    localparam int KW = clog2(NUM_W);
    localparam int AW = WIDTH_A + 1;
    localparam logic signed [ACC_W-1:0] HMAX = ACC_W'((1 << WIDTH_A) - 1);

    if (ACC_W < WIDTH_W + WIDTH_A + 2 + clog2(max_int(NUM_A, NUM_H) + 1)) begin : g_acc_chk
        $error("mlp_seq_engine: ACC_W too narrow for the worst-case dot product");
    end
    if ((1 << OUTWIDTH) < NUM_C) begin : g_out_chk
        $error("mlp_seq_engine: OUTWIDTH cannot encode NUM_C classes");
    end

    logic signed [WIDTH_W-1:0] w_arr  [NUM_W];
    logic signed [ACC_W-1:0]   b0_ext [NUM_H];
    logic signed [ACC_W-1:0]   b1_ext [NUM_C];

    for (genvar k = 0; k < NUM_W; k++) begin : g_w
        assign w_arr[k] = weights[w_lsb(k, NUM_W, WIDTH_W) +: WIDTH_W];
    end
    for (genvar h = 0; h < NUM_H; h++) begin : g_b0
        logic [WIDTH_B0-1:0] b;
        assign b         = biases[b0_lsb(h, WIDTH_B0) +: WIDTH_B0];
        assign b0_ext[h] = {{(ACC_W-WIDTH_B0){b[WIDTH_B0-1]}}, b};
    end
    for (genvar c = 0; c < NUM_C; c++) begin : g_b1
        logic [WIDTH_B1-1:0] b;
        assign b         = biases[b1_lsb(c, NUM_H, WIDTH_B0, WIDTH_B1) +: WIDTH_B1];
        assign b1_ext[c] = {{(ACC_W-WIDTH_B1){b[WIDTH_B1-1]}}, b};
    end

    state_e                  state_q, state_d;
    logic [WIDTH_A-1:0]      x_q     [NUM_A];
    logic [WIDTH_A-1:0]      h_act_q [NUM_H];
    logic [TW-1:0]           t_q;
    logic [NW-1:0]           n_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] max_q;
    logic [OUTWIDTH-1:0]     best_q;
    logic [OUTWIDTH-1:0]     out_q;

    logic                    mac_en;
    logic                    mac_load;
    logic signed [ACC_W-1:0] mac_bias;
    logic signed [AW-1:0]    mac_a;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] shifted;
    logic [WIDTH_A-1:0]      act;
    logic                    t_last0, t_last1, n_last0, n_last1, better;

    assign t_last0 = (t_q == TW'(NUM_A - 1));
    assign t_last1 = (t_q == TW'(NUM_H - 1));
    assign n_last0 = (n_q == NW'(NUM_H - 1));
    assign n_last1 = (n_q == NW'(NUM_C - 1));

    // Weights are consumed in bus order across both layers, so one pointer walks them all.
    mlp_mac #(.AW(AW), .WW(WIDTH_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .load  (mac_load),
        .bias  (mac_bias),
        .a     (mac_a),
        .w     (w_arr[k_q]),
        .sum   (mac_sum)
    );

    always_comb begin
        state_d  = state_q;
        mac_en   = 1'b0;
        mac_load = (t_q == '0);
        mac_bias = '0;
        mac_a    = '0;
        unique case (state_q)
            IDLE: if (in_valid) state_d = L0;
            L0: begin
                mac_en   = 1'b1;
                mac_bias = b0_ext[n_q[HW-1:0]];
                mac_a    = {1'b0, x_q[t_q[XW-1:0]]};
                if (t_last0 && n_last0) state_d = L1;
            end
            L1: begin
                mac_en   = 1'b1;
                mac_bias = b1_ext[n_q[CW-1:0]];
                mac_a    = {1'b0, h_act_q[t_q[HW-1:0]]};
                if (t_last1 && n_last1) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shifted = mac_sum >>> QSHIFT;
        act     = '0;
        if (!mac_sum[ACC_W-1]) begin
            act = (shifted > HMAX) ? HMAX[WIDTH_A-1:0] : shifted[WIDTH_A-1:0];
        end
        better = (n_q == '0) || (mac_sum > max_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NUM_A; a++) x_q[a] <= '0;
            for (int h = 0; h < NUM_H; h++) h_act_q[h] <= '0;
            t_q    <= '0;
            n_q    <= '0;
            k_q    <= '0;
            max_q  <= '0;
            best_q <= '0;
            out_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    for (int a = 0; a < NUM_A; a++) x_q[a] <= inp[a*WIDTH_A +: WIDTH_A];
                    t_q <= '0;
                    n_q <= '0;
                    k_q <= '0;
                end
                L0: begin
                    k_q <= k_q + KW'(1);
                    if (t_last0) begin
                        t_q                   <= '0;
                        h_act_q[n_q[HW-1:0]] <= act;
                        n_q                   <= n_last0 ? '0 : n_q + NW'(1);
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                L1: begin
                    k_q <= k_q + KW'(1);
                    if (t_last1) begin
                        t_q <= '0;
                        n_q <= n_last1 ? '0 : n_q + NW'(1);
                        if (better) begin
                            max_q  <= mac_sum;
                            best_q <= OUTWIDTH'(n_q);
                        end
                        if (n_last1) out_q <= better ? OUTWIDTH'(n_q) : best_q;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed and randomized checks of mlp_seq_engine against an integer reference model.
`timescale 1ns/1ps
module tb_mlp_seq_engine;
    localparam int NA  = 6;
    localparam int WA  = 4;
    localparam int NH  = 3;
    localparam int NC  = 3;
    localparam int WW  = 8;
    localparam int WB0 = 10;
    localparam int WB1 = 11;
    localparam int OW  = 2;
    localparam int NW  = NA*NH + NH*NC;
    localparam int LAT = NA*NH + NH*NC;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     out_ready = 1'b0;
    logic                     in_ready, out_valid, busy;
    logic [OW-1:0]            out_w;
    logic [NA*WA-1:0]         inp = '0;
    logic [NW*WW-1:0]         weights = '0;
    logic [NH*WB0+NC*WB1-1:0] biases = '0;

    int total = 0;
    int bad   = 0;
    int xs  [NA];
    int ws  [NW];
    int b0s [NH];
    int b1s [NC];

    always #5 clk = ~clk;

    mlp_seq_engine #(
        .NUM_A(NA), .WIDTH_A(WA), .NUM_H(NH), .NUM_C(NC), .WIDTH_W(WW),
        .WIDTH_B0(WB0), .WIDTH_B1(WB1), .OUTWIDTH(OW), .QSHIFT(4), .ACC_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inp(inp), .weights(weights), .biases(biases), .out_valid(out_valid),
        .out_ready(out_ready), .out(out_w), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < NA; i++) xs[i] = 0;
        for (int i = 0; i < NW; i++) ws[i] = 0;
        for (int i = 0; i < NH; i++) b0s[i] = 0;
        for (int i = 0; i < NC; i++) b1s[i] = 0;
    endtask

    task automatic pack();
        int v;
        for (int a = 0; a < NA; a++) begin v = xs[a]; inp[a*WA +: WA] = v[WA-1:0]; end
        for (int k = 0; k < NW; k++) begin v = ws[k]; weights[(NW-1-k)*WW +: WW] = v[WW-1:0]; end
        for (int h = 0; h < NH; h++) begin v = b0s[h]; biases[h*WB0 +: WB0] = v[WB0-1:0]; end
        for (int c = 0; c < NC; c++) begin v = b1s[c]; biases[NH*WB0 + c*WB1 +: WB1] = v[WB1-1:0]; end
    endtask

    // Straight from the arithmetic: ReLU, divide by 16, saturate at 15, strict-greater argmax.
    function automatic int model();
        int act [NH];
        int acc, best, bmax;
        best = 0;
        bmax = 0;
        for (int h = 0; h < NH; h++) begin
            acc = b0s[h];
            for (int a = 0; a < NA; a++) acc += xs[a] * ws[h*NA + a];
            if (acc < 0) act[h] = 0;
            else begin
                act[h] = acc / 16;
                if (act[h] > 15) act[h] = 15;
            end
        end
        for (int c = 0; c < NC; c++) begin
            acc = b1s[c];
            for (int h = 0; h < NH; h++) acc += act[h] * ws[NA*NH + c*NH + h];
            if (c == 0 || acc > bmax) begin
                bmax = acc;
                best = c;
            end
        end
        return best;
    endfunction

    task automatic start_vec(input string tag);
        pack();
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy_after_accept"}, busy, 1);
        check({tag, "_in_ready_after_accept"}, in_ready, 0);
    endtask

    task automatic wait_result(input string tag, input int exp);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, LAT);
        check({tag, "_class"}, out_w, exp);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after_release"}, in_ready, 1);
        check({tag, "_out_valid_after_release"}, out_valid, 0);
    endtask

    task automatic run(input string tag, input int exp);
        start_vec(tag);
        wait_result(tag, exp);
        release_result(tag);
    endtask

    task automatic set_h0_class2();
        clear_vec();
        for (int a = 0; a < NA; a++) begin xs[a] = 15; ws[a] = 1; end
        ws[NA*NH + 2*NH + 0] = 1;
    endtask

    initial begin
        clear_vec();
        pack();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out_w, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // Zero weights: classes decided by output biases alone, tie goes to lower index.
        clear_vec();
        b1s[0] = -1; b1s[1] = 5; b1s[2] = 5;
        run("tie", 1);

        set_h0_class2();
        run("h0_five", 2);

        clear_vec();
        for (int a = 0; a < NA; a++) begin xs[a] = 15; ws[a] = 127; end
        ws[NA*NH + 0] = 1;
        b1s[1] = 14;
        run("clamp", 0);

        clear_vec();
        for (int a = 0; a < NA; a++) xs[a] = $urandom_range(0, 15);
        b0s[0] = -100;
        ws[NA*NH + 0] = -1;
        b1s[1] = -1; b1s[2] = -1;
        run("relu", 0);

        // Result hold under backpressure while new input pulses are offered.
        set_h0_class2();
        start_vec("stall");
        wait_result("stall", 2);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            inp = NA*WA'($urandom);
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_out", out_w, 2);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        pack();
        release_result("stall");
        @(posedge clk); #1;
        check("stall_no_capture", busy, 0);

        // Abort in the third output-layer cycle; previous out (2) must clear.
        for (int a = 0; a < NA; a++) xs[a] = $urandom_range(0, 15);
        start_vec("abort");
        repeat (LAT - NH*NC + 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out", out_w, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_h0_class2();
        run("after_abort", 2);

        for (int n = 0; n < 40; n++) begin
            for (int a = 0; a < NA; a++) xs[a] = $urandom_range(0, 15);
            for (int k = 0; k < NW; k++) ws[k] = $urandom_range(0, 255) - 128;
            for (int h = 0; h < NH; h++) b0s[h] = $urandom_range(0, 1023) - 512;
            for (int c = 0; c < NC; c++) b1s[c] = $urandom_range(0, 2047) - 1024;
            start_vec("rand");
            wait_result("rand", model());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rand_hold", out_valid, 1);
            release_result("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_seq_engine.md
# mlp_seq_engine

Sequential, parametrised successor to the fully-parallel printed-MLP `top` datapath. It evaluates a two-layer MLP (NUM_A inputs → NUM_H ReLU hidden neurons → NUM_C output classes) with a single time-multiplexed MAC, and returns the argmax class index through valid/ready handshakes. The flat `weights`/`biases` bus format matches the existing benches, so the existing stimulus and fault-injection flows reuse this block unchanged apart from the handshake.

## Interface
- NUM_A, 6: input features
- WIDTH_A, 4: unsigned input width, also the hidden-activation width
- NUM_H, 3: hidden neurons
- NUM_C, 3: output classes
- WIDTH_W, 8: signed weight width; NUM_W = NUM_A*NUM_H + NUM_H*NUM_C
- WIDTH_B0, 10: signed hidden bias width
- WIDTH_B1, 11: signed output bias width
- OUTWIDTH, 2: class index width, ≥ clog2(NUM_C)
- QSHIFT, 4: hidden requantisation right shift
- ACC_W, 24: signed accumulator width
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- inp  in  NUM_A*WIDTH_A  feature a at [(a+1)*WIDTH_A-1 : a*WIDTH_A]
- weights  in  NUM_W*WIDTH_W  weight k at [(NUM_W-k)*WIDTH_W-1 -: WIDTH_W] (k=0 at MSB); layer-0 k=h*NUM_A+a, layer-1 k=NUM_A*NUM_H+c*NUM_H+h
- biases  in  NUM_H*WIDTH_B0+NUM_C*WIDTH_B1  layer-0 bias h at [(h+1)*WIDTH_B0-1 -: WIDTH_B0] (LSB region); layer-1 bias c at NUM_H*WIDTH_B0+(c+1)*WIDTH_B1-1 -: WIDTH_B1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  OUTWIDTH  argmax class index
- busy  out  1  high in L0, L1 or DONE

## Operation
- FSM: IDLE → L0 → L1 → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register `inp`; go to L0 with neuron/term counters 0.
- L0: one MAC per cycle; first term of each neuron loads acc = sext(b0[h]) + x[0]*w; later terms accumulate. Inputs zero-extended to WIDTH_A+1 signed before multiplying. On the last term: h_act[h] = min(max(acc,0) >>> QSHIFT, 2^WIDTH_A−1). After neuron NUM_H−1, go to L1.
- L1: same MAC over h_act with b1[c]; no ReLU. On each class's last term compare the final sum with the running max: class 0 always loads; later classes replace only if strictly greater (ties → lowest index). After class NUM_C−1, load `out`, go to DONE.
- DONE: out_valid=1, `out` stable; on out_ready go to IDLE. in_ready=0 (no overlap between result hold and new capture).
- `weights`/`biases` are not registered; the driver holds them stable while busy.
- ACC_W must be ≥ WIDTH_W+WIDTH_A+2+clog2(max(NUM_A,NUM_H)+1); elaboration-time assertion.

## Timing
- Reset: state=IDLE, out=0, out_valid=0, busy=0, accumulators/counters/h_act=0; in_ready=1 during and after reset.
- Accept at edge T; out_valid rises after edge T+NUM_A*NUM_H+NUM_H*NUM_C (27 with defaults).
- out_valid/out hold indefinitely while out_ready=0; in_valid is ignored outside IDLE.
- Result handshake at edge R → in_ready=1 after R; earliest next accept at R+1.
- rst_n low mid-computation: immediate abort to reset values; no partial result is ever presented.

## Structure
- Package `mlp_seq_pkg`: FSM state enum {IDLE,L0,L1,DONE}, clog2 function, weight/bias slice-index functions.
- Sub-module `mlp_mac`: signed multiply, bias-load/accumulate select, ACC_W register; instantiated once, shared by both layers.

## Test plan
- All weights 0, b0=0, b1={c0:−1,c1:5,c2:5}: out=1 (tie → lowest), out_valid exactly 27 cycles after accept.
- Inputs all 15; neuron-0 layer-0 weights 1, others 0; b=0; class-2 weight on h0 = 1, others 0: h0=90>>>4=5, out=2.
- Inputs 15, neuron-0 weights 127 (acc 11430 → clamp 15); class-0 weight on h0 = 1, b1 class1 = 14: out=0.
- b0[0]=−100, weights 0 except class-0 weight on h0 = −1; b1={0,−1,−1}: ReLU gives h0=0, out=0.
- out_ready held low 10 cycles: out_valid/out stable, in_ready=0, in_valid pulses ignored; release → IDLE next cycle.
- rst_n asserted at L1 cycle 3: outputs at reset values immediately; a fresh vector then yields the correct class with full latency.
